// File: rtl/plic_target_arbiter_pkg.sv
// Shared types and defaults for the per-target PLIC core: gateway state
// encodings, the reserved "no interrupt" ID and default widths.
package plic_target_arbiter_pkg;

    localparam int DEFAULT_NUM_SOURCES = 8;
    localparam int DEFAULT_PRIO_WIDTH  = 3;
    localparam int DEFAULT_ID_WIDTH    = 4;

    localparam int PLIC_NO_IRQ_ID = 0;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_gateway_fsm.sv
// Per-source interrupt gateway: latches a level request as PENDING, holds it
// CLAIMED while the hart services it, and returns to IDLE on completion.
module plic_gateway_fsm
    import plic_target_arbiter_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      signal_i,
    input  logic      claim_hit_i,
    input  logic      complete_hit_i,
    output gw_state_e state_o
);

    gw_state_e state_q, state_d;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            GW_IDLE:    if (signal_i)       state_d = GW_PENDING;
            GW_PENDING: if (claim_hit_i)    state_d = GW_CLAIMED;
            GW_CLAIMED: if (complete_hit_i) state_d = GW_IDLE;
            default:                        state_d = GW_IDLE;
        endcase
    end

    // NOTE: non-blocking assignment for flops so all state updates see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= GW_IDLE;
        else       state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/plic_target_arbiter.sv
// Per-target PLIC core: source gateways, priority/threshold arbitration,
// external-interrupt line and the claim/complete handshake.
module plic_target_arbiter
    import plic_target_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
    parameter int PRIO_WIDTH  = DEFAULT_PRIO_WIDTH,
    parameter int ID_WIDTH    = DEFAULT_ID_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_SOURCES-1:0]            source_signal_i,
    input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] source_priority_i,
    input  logic [PRIO_WIDTH-1:0]             target_threshold_i,
    input  logic                              claim_i,
    input  logic                              complete_i,
    input  logic [ID_WIDTH-1:0]               complete_id_i,
    output logic                              claim_valid_o,
    output logic [ID_WIDTH-1:0]               claim_id_o,
    output logic                              target_eip_o
);

    gw_state_e             gw_state [NUM_SOURCES];
    logic [PRIO_WIDTH-1:0] prio     [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] pending, claim_hit, complete_hit;

    logic [ID_WIDTH-1:0]   best_id_q,   best_id_d;
    logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
    logic                  eip_q,       eip_d;
    logic                  claim_valid_q, claim_valid_d;
    logic [ID_WIDTH-1:0]   claim_id_q,  claim_id_d;
    logic                  best_still_pending, claim_accept;

    for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_src
        assign prio[k]    = source_priority_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        assign pending[k] = (gw_state[k] == GW_PENDING);

        plic_gateway_fsm u_gateway (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .signal_i       (source_signal_i[k]),
            .claim_hit_i    (claim_hit[k]),
            .complete_hit_i (complete_hit[k]),
            .state_o        (gw_state[k])
        );
    end

    // Ascending scan with strict '>' so equal priorities resolve to the lowest ID.
    always_comb begin
        best_id_d   = ID_WIDTH'(PLIC_NO_IRQ_ID);
        best_prio_d = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (pending[k] && (prio[k] != '0) && (prio[k] > best_prio_d)) begin
                best_prio_d = prio[k];
                best_id_d   = ID_WIDTH'(k + 1);
            end
        end
    end

    // A registered winner that already left PENDING (back-to-back claim) is refused.
    always_comb begin
        best_still_pending = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if ((best_id_q == ID_WIDTH'(k + 1)) && pending[k]) best_still_pending = 1'b1;
        end
        claim_accept = claim_i && best_still_pending && (best_prio_q > target_threshold_i);

        claim_hit    = '0;
        complete_hit = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            claim_hit[k]    = claim_accept && (best_id_q == ID_WIDTH'(k + 1));
            complete_hit[k] = complete_i && (complete_id_i == ID_WIDTH'(k + 1));
        end

        claim_valid_d = claim_i;
        claim_id_d    = claim_id_q;
        if (claim_i) claim_id_d = claim_accept ? best_id_q : ID_WIDTH'(PLIC_NO_IRQ_ID);

        // The live arbitration term drops EIP as soon as the claimed source leaves PENDING.
        eip_d = (best_prio_q > target_threshold_i) && (best_prio_d > target_threshold_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_id_q     <= '0;
            best_prio_q   <= '0;
            eip_q         <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            best_id_q     <= best_id_d;
            best_prio_q   <= best_prio_d;
            eip_q         <= eip_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
        end
    end

    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign target_eip_o  = eip_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Self-checking bench for plic_target_arbiter: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a set-based model.
module tb_plic_target_arbiter;

    localparam int NS = 8;
    localparam int PW = 3;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     sig;
    logic [NS*PW-1:0]  prio_flat;
    logic [PW-1:0]     thr;
    logic              claim, complete;
    logic [IW-1:0]     cid_in;
    logic              cv, eip;
    logic [IW-1:0]     cid;
    logic [PW-1:0]     prio [1:NS];
    logic [IW-1:0]     id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        prio_flat = '0;
        for (int k = 1; k <= NS; k++) prio_flat[(k-1)*PW +: PW] = prio[k];
    end

    plic_target_arbiter #(
        .NUM_SOURCES (NS),
        .PRIO_WIDTH  (PW),
        .ID_WIDTH    (IW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .source_signal_i    (sig),
        .source_priority_i  (prio_flat),
        .target_threshold_i (thr),
        .claim_i            (claim),
        .complete_i         (complete),
        .complete_id_i      (cid_in),
        .claim_valid_o      (cv),
        .claim_id_o         (cid),
        .target_eip_o       (eip)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_id(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sources are tracked as two sets (pending, claimed); outputs follow the
    // documented latencies: winner visible one cycle after pending, EIP one after that.
    bit            m_pend [1:NS];
    bit            m_clm  [1:NS];
    logic [IW-1:0] m_bid   = '0;
    logic [PW-1:0] m_bprio = '0;
    logic          m_eip   = 1'b0;
    logic          m_cv    = 1'b0;
    logic [IW-1:0] m_cid   = '0;
    bit            chk_en  = 1'b0;

    function automatic void winner(output logic [IW-1:0] wid, output logic [PW-1:0] wpr);
        wid = '0;
        wpr = '0;
        for (int k = 1; k <= NS; k++) begin
            if (m_pend[k] && prio[k] != 0 && prio[k] > wpr) begin
                wid = IW'(k);
                wpr = prio[k];
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [IW-1:0] wid;
        logic [PW-1:0] wpr;
        bit            acc;
        if (rst) begin
            for (int k = 1; k <= NS; k++) begin
                m_pend[k] = 1'b0;
                m_clm[k]  = 1'b0;
            end
            m_bid = '0; m_bprio = '0; m_eip = 1'b0; m_cv = 1'b0; m_cid = '0;
        end else begin
            winner(wid, wpr);
            acc   = claim && (m_bid != 0) && (m_bprio > thr) && m_pend[m_bid];
            m_eip = (m_bprio > thr) && (wpr > thr);
            m_cv  = claim;
            if (claim) m_cid = acc ? m_bid : '0;
            for (int k = 1; k <= NS; k++) begin
                if (m_clm[k]) begin
                    if (complete && cid_in == IW'(k)) m_clm[k] = 1'b0;
                end else if (m_pend[k]) begin
                    if (acc && m_bid == IW'(k)) begin
                        m_pend[k] = 1'b0;
                        m_clm[k]  = 1'b1;
                    end
                end else if (sig[k-1]) begin
                    m_pend[k] = 1'b1;
                end
            end
            m_bid   = wid;
            m_bprio = wpr;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk1  ("model_eip",         eip, m_eip);
            chk1  ("model_claim_valid", cv,  m_cv);
            chk_id("model_claim_id",    cid, m_cid);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clear_all();
        sig = '0;
        thr = '0;
        for (int k = 1; k <= NS; k++) prio[k] = '0;
        do_reset();
    endtask

    task automatic do_claim(output logic [IW-1:0] got);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        chk1("claim_valid_pulse", cv, 1'b1);
        got = cid;
    endtask

    initial begin
        rst = 1'b1; sig = '0; thr = '0; claim = 1'b0; complete = 1'b0; cid_in = '0;
        for (int k = 1; k <= NS; k++) prio[k] = '0;
        tick(2);
        rst = 1'b0;

        // 1: reset state, empty claim
        chk1  ("t1_rst_eip",         eip, 1'b0);
        chk1  ("t1_rst_claim_valid", cv,  1'b0);
        chk_id("t1_rst_claim_id",    cid, 0);
        do_claim(id);
        chk_id("t1_claim_empty", id, 0);
        tick(1);
        chk1("t1_valid_one_cycle", cv, 1'b0);

        // 2: latency, claim, re-forward after completion
        clear_all();
        prio[3] = 3'd5; thr = 3'd2; sig[2] = 1'b1;
        tick(2);
        chk1("t2_eip_early", eip, 1'b0);
        tick(1);
        chk1("t2_eip_3cyc", eip, 1'b1);
        do_claim(id);
        chk_id("t2_claim_id", id, 3);
        tick(1);
        chk1("t2_eip_cleared", eip, 1'b0);
        complete = 1'b1; cid_in = 4'd3;
        tick(1);
        complete = 1'b0;
        tick(2);
        chk1("t2_refwd_early", eip, 1'b0);
        tick(1);
        chk1("t2_refwd_eip", eip, 1'b1);

        // 3: tie to lowest ID, higher priority first, back-to-back claims
        clear_all();
        prio[2] = 3'd4; prio[5] = 3'd4; sig = 8'b0001_0010;
        tick(3);
        do_claim(id);
        chk_id("t3_tie_low_id", id, 2);
        tick(2);
        do_claim(id);
        chk_id("t3_tie_second", id, 5);
        do_reset();
        prio[6] = 3'd7; sig[5] = 1'b1;
        tick(3);
        claim = 1'b1;
        tick(1);
        chk_id("t3_b2b_first", cid, 6);
        tick(1);
        claim = 1'b0;
        chk1  ("t3_b2b_valid", cv, 1'b1);
        chk_id("t3_b2b_second", cid, 0);
        do_claim(id);
        chk_id("t3_after_b2b", id, 2);

        // 4: threshold equal to priority blocks; lowering it / raising prio
        clear_all();
        prio[4] = 3'd3; thr = 3'd3; sig[3] = 1'b1;
        tick(4);
        chk1("t4_eip_blocked", eip, 1'b0);
        do_claim(id);
        chk_id("t4_claim_blocked", id, 0);
        thr = 3'd2;
        tick(2);
        chk1("t4_thr_lowered", eip, 1'b1);
        prio[4] = 3'd0;
        tick(2);
        chk1("t4_prio_zeroed", eip, 1'b0);

        // 5: stray completes ignored; simultaneous claim + complete
        clear_all();
        prio[2] = 3'd5; prio[1] = 3'd3; sig = 8'b0000_0011;
        tick(1);
        sig = '0;
        tick(2);
        chk1("t5_latched_eip", eip, 1'b1);
        do_claim(id);
        chk_id("t5_claim_src2", id, 2);
        complete = 1'b1; cid_in = 4'd7;
        tick(1);
        cid_in = 4'd0;
        tick(1);
        complete = 1'b0;
        chk1("t5_stray_complete", eip, 1'b1);
        claim = 1'b1; complete = 1'b1; cid_in = 4'd2;
        tick(1);
        claim = 1'b0; complete = 1'b0;
        chk_id("t5_simul_claim", cid, 1);
        tick(2);
        chk1("t5_none_pending", eip, 1'b0);
        sig[1] = 1'b1;
        tick(1);
        sig = '0;
        tick(2);
        chk1("t5_src2_repend", eip, 1'b1);
        do_claim(id);
        chk_id("t5_src2_completed", id, 2);

        // 6: reset mid-operation
        clear_all();
        prio[1] = 3'd2; sig[0] = 1'b1;
        tick(3);
        do_claim(id);
        chk_id("t6_claim_src1", id, 1);
        do_reset();
        chk1  ("t6_rst_eip",   eip, 1'b0);
        chk1  ("t6_rst_valid", cv,  1'b0);
        chk_id("t6_rst_id",    cid, 0);
        tick(2);
        chk1("t6_repend_early", eip, 1'b0);
        tick(1);
        chk1("t6_repend_eip", eip, 1'b1);
        do_claim(id);
        chk_id("t6_reclaim", id, 1);

        // random phase, checked by the model every cycle
        clear_all();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) sig = NS'($urandom);
            if ($urandom_range(0, 15) == 0) prio[$urandom_range(1, NS)] = PW'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) thr = PW'($urandom_range(0, 4));
            claim    = ($urandom_range(0, 2) == 0);
            complete = ($urandom_range(0, 2) == 0);
            cid_in   = IW'($urandom_range(0, 10));
            tick(1);
        end
        rst = 1'b0; claim = 1'b0; complete = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
